uart_tx_framer: RTL and testbench

Parametrised UART transmit framer that serialises one parallel word per handshake into a complete frame on a single line: start bit, LSB-first data, optional parity, then one or two stop bits. It is the successor to the fixed start/data/parity/stop output select. Bit sequencing, shifting, parity generation and the framing state machine are all internal. It sits between the transmit FIFO/host handshake and the TX pad. Bit timing is taken from an external baud-tick generator.

---
 rtl/uart_tx_framer.sv | 126 ++++++++++++
 tb/tb_uart_tx_framer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises one DATA_WIDTH word per valid/ready handshake into start, LSB-first data, optional parity and 1-2 stop bits.
// Ports: clk/rst (sync active-high), baud_tick (one pulse per bit period), tx_valid/tx_ready/tx_data (word handshake),
// parity_mode (00/11 none, 01 odd, 10 even), stop_two (two stop bits), tx_out (registered line, idle high),
// tx_busy (frame in flight), tx_done (registered one-cycle pulse when the frame ends).
// Build option: define UART_TX_PARITY_EN to include the parity bit; otherwise parity_mode is ignored.
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_two,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done
);
  localparam int CW = $clog2(DATA_WIDTH);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, WAIT, START, DATA, PARITY, STOP} state_t;
  logic par, par_n, par_en, par_en_n;
`else
  typedef enum logic [2:0] {IDLE, WAIT, START, DATA, STOP} state_t;
  logic unused_parity;
  assign unused_parity = ^parity_mode;
`endif
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] sh, sh_n;
  logic [CW-1:0] cnt, cnt_n;
  logic two, two_n, stop_cnt, stop_cnt_n, out_n, done_n;
  assign tx_ready = state == IDLE;
  assign tx_busy  = state != IDLE;
  always_comb begin
    state_n    = state;
    sh_n       = sh;
    cnt_n      = cnt;
    two_n      = two;
    stop_cnt_n = stop_cnt;
    out_n      = tx_out;
    done_n     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n      = par;
    par_en_n   = par_en;
`endif
    case (state)
      IDLE: if (tx_valid) begin
        state_n    = WAIT;
        sh_n       = tx_data;
        two_n      = stop_two;
        stop_cnt_n = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_n   = parity_mode == 2'b01 || parity_mode == 2'b10;
        par_n      = ^tx_data ^ (parity_mode == 2'b01);
`endif
      end
      WAIT: if (baud_tick) begin
        state_n = START;
        out_n   = 1'b0;
      end
      START: if (baud_tick) begin
        state_n = DATA;
        out_n   = sh[0];
        sh_n    = sh >> 1;
        cnt_n   = '0;
      end
      // cnt holds the index of the bit currently on the line
      DATA: if (baud_tick) begin
        if (cnt == CW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_n = par_en ? PARITY : STOP;
          out_n   = par_en ? par : 1'b1;
`else
          state_n = STOP;
          out_n   = 1'b1;
`endif
        end else begin
          cnt_n = cnt + 1'b1;
          out_n = sh[0];
          sh_n  = sh >> 1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_tick) begin
        state_n = STOP;
        out_n   = 1'b1;
      end
`endif
      STOP: if (baud_tick) begin
        stop_cnt_n = 1'b1;
        state_n    = (two && !stop_cnt) ? STOP : IDLE;
        done_n     = !(two && !stop_cnt);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_out   <= 1'b1;
      tx_done  <= 1'b0;
      sh       <= '0;
      cnt      <= '0;
      two      <= 1'b0;
      stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
      par_en   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      tx_out   <= out_n;
      tx_done  <= done_n;
      sh       <= sh_n;
      cnt      <= cnt_n;
      two      <= two_n;
      stop_cnt <= stop_cnt_n;
`ifdef UART_TX_PARITY_EN
      par      <= par_n;
      par_en   <= par_en_n;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed and randomized frames compared against an expected bit list built from the frame rules.
module tb_uart_tx_framer;
  localparam int DW = 8;
  logic clk = 1'b0, rst = 1'b1, baud_tick = 1'b0, tx_valid = 1'b0, stop_two = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic [1:0] parity_mode = 2'b00;
  logic tx_ready, tx_out, tx_busy, tx_done;
  int checks = 0, errors = 0;

  uart_tx_framer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .parity_mode(parity_mode), .stop_two(stop_two),
    .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wiggle(input bit en);
    if (en) begin
      tx_valid    = 1'($urandom);
      tx_data     = DW'($urandom);
      parity_mode = 2'($urandom);
      stop_two    = 1'($urandom);
    end
  endtask

  // Expected line value after each baud tick, derived directly from the frame format.
  task automatic build_frame(input logic [DW-1:0] d, input logic [1:0] pm, input logic two, output bit q[$]);
    int ones;
    q = {};
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) q.push_back(((d >> i) & 1) != 0);
    ones = $countones(d);
`ifdef UART_TX_PARITY_EN
    if (pm == 2'b10) q.push_back(ones % 2 == 1);
    if (pm == 2'b01) q.push_back(ones % 2 == 0);
`endif
    q.push_back(1'b1);
    if (two) q.push_back(1'b1);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [1:0] pm, input logic two, input int gap,
                      input bit wig, input bit hold, input bit tick_at_accept);
    bit q[$];
    bit cur;
    build_frame(d, pm, two, q);
    tx_valid = 1'b1; tx_data = d; parity_mode = pm; stop_two = two; baud_tick = tick_at_accept;
    step();
    baud_tick = 1'b0; tx_valid = hold;
    chk("accept_ready", tx_ready, 0);
    chk("accept_busy", tx_busy, 1);
    chk("accept_done", tx_done, 0);
    chk("accept_line", tx_out, 1);
    cur = 1'b1;
    for (int i = 0; i <= q.size(); i++) begin
      for (int g = 0; g < gap; g++) begin
        wiggle(wig);
        step();
        chk("hold_line", tx_out, cur);
        chk("frame_ready", tx_ready, 0);
        chk("frame_done", tx_done, 0);
      end
      baud_tick = 1'b1;
      step();
      baud_tick = 1'b0;
      if (i < q.size()) begin
        cur = q[i];
        chk("bit", tx_out, cur);
        chk("bit_busy", tx_busy, 1);
        chk("bit_done", tx_done, 0);
      end else begin
        chk("end_done", tx_done, 1);
        chk("end_ready", tx_ready, 1);
        chk("end_line", tx_out, 1);
        chk("end_busy", tx_busy, 0);
      end
    end
    if (wig) tx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      baud_tick = 1'($urandom);
      step();
      chk("idle_line", tx_out, 1);
      chk("idle_ready", tx_ready, 1);
      chk("idle_done", tx_done, 0);
    end
    baud_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    chk("rst_line", tx_out, 1);
    chk("rst_done", tx_done, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_ready", tx_ready, 1);
    rst = 1'b0;
    idle(3);
    send(8'hA5, 2'b00, 1'b0, 15, 1'b0, 1'b0, 1'b0);
    idle(2);
    send(8'h03, 2'b10, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    idle(1);
    send(8'h03, 2'b01, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    idle(1);
    send(8'h03, 2'b11, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    idle(1);
    send(8'h00, 2'b00, 1'b1, 4, 1'b0, 1'b0, 1'b0);
    send(8'h55, 2'b00, 1'b0, 7, 1'b0, 1'b1, 1'b0);
    send(8'hAA, 2'b00, 1'b0, 7, 1'b0, 1'b0, 1'b0);
    idle(2);
    send(8'h81, 2'b10, 1'b0, 2, 1'b0, 1'b0, 1'b1);
    idle(1);
    send(8'h5A, 2'b01, 1'b1, 4, 1'b1, 1'b0, 1'b0);
    idle(1);
    // Abort a frame while data bit 3 is on the line.
    tx_valid = 1'b1; tx_data = 8'h96; parity_mode = 2'b00; stop_two = 1'b0;
    step();
    tx_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      repeat (3) step();
      baud_tick = 1'b1;
      step();
      baud_tick = 1'b0;
    end
    chk("abort_bit3", tx_out, 0);
    rst = 1'b1; baud_tick = 1'b1; tx_valid = 1'b1;
    step();
    rst = 1'b0; baud_tick = 1'b0; tx_valid = 1'b0;
    chk("abort_line", tx_out, 1);
    chk("abort_ready", tx_ready, 1);
    chk("abort_busy", tx_busy, 0);
    chk("abort_done", tx_done, 0);
    idle(40);
    send(8'h3C, 2'b00, 1'b0, 5, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 12; r++) begin
      idle(int'($urandom_range(3, 0)));
      send(DW'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(5, 0)),
           1'b1, 1'b0, 1'($urandom));
    end
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
